vga_scan_ctrl: RTL and testbench

- Raster scan generator and pixel sink for the visualization modules, covering the other end of their coordinate/colour interface.
- Produces the pixel coordinates (oX, oY) and a once-per-frame strobe (oFS), which the visual_* modules consume.
- Samples the colour they return (iR, iG, iB) and drives the VGA DAC colour, sync and blank pins with matching latency.
- Default timing is 640x480 @ 60 Hz on a 25.175 MHz pixel clock.

---
 rtl/vga_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_vga_scan_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// Raster scan generator and pixel sink: drives coordinates to the visual modules and
// returns their colour to the VGA DAC with sync/blank aligned to the colour sample.
module vga_scan_ctrl #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int PIPE   = 1
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oACTIVE,
  output logic       oFS,
  input  logic [9:0] iR,
  input  logic [9:0] iG,
  input  logic [9:0] iB,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACT);
  localparam logic [9:0] H_SS_C   = 10'(H_ACT + H_FP);
  localparam logic [9:0] H_SE_C   = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_TOT - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACT);
  localparam logic [9:0] V_SS_C   = 10'(V_ACT + V_FP);
  localparam logic [9:0] V_SE_C   = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOT - 1);

  logic [9:0] hCnt_r;
  logic [9:0] vCnt_r;
  logic       hAct_s;
  logic       vAct_s;
  logic       hsN_s;
  logic       vsN_s;
  logic       fs_s;

  // Element 0 is the coordinate stage; the last element feeds the output stage.
  logic actD_r [0:PIPE-1];
  logic hsD_r  [0:PIPE-1];
  logic vsD_r  [0:PIPE-1];

  // Horizontal and vertical scan counters.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hCnt_r <= 10'd0;
      vCnt_r <= 10'd0;
    end else if (hCnt_r == H_LAST_C) begin
      hCnt_r <= 10'd0;
      if (vCnt_r == V_LAST_C) begin
        vCnt_r <= 10'd0;
      end else begin
        vCnt_r <= vCnt_r + 10'd1;
      end
    end else begin
      hCnt_r <= hCnt_r + 10'd1;
    end
  end

  // Region decode of the current counter position.
  always_comb begin
    hAct_s = (hCnt_r < H_ACT_C);
    vAct_s = (vCnt_r < V_ACT_C);
    hsN_s  = !((hCnt_r >= H_SS_C) && (hCnt_r < H_SE_C));
    vsN_s  = !((vCnt_r >= V_SS_C) && (vCnt_r < V_SE_C));
    fs_s   = (hCnt_r == 10'd0) && (vCnt_r == V_ACT_C);
  end

  // Coordinate stage plus the act/sync alignment chain.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oX      <= 10'd0;
      oY      <= 10'd0;
      oACTIVE <= 1'b0;
      oFS     <= 1'b0;
      for (int i = 0; i < PIPE; i++) begin
        actD_r[i] <= 1'b0;
        hsD_r[i]  <= 1'b1;
        vsD_r[i]  <= 1'b1;
      end
    end else begin
      // Out-of-area coordinates clamp to 0 so downstream divisors stay bounded.
      oX        <= hAct_s ? hCnt_r : 10'd0;
      oY        <= vAct_s ? vCnt_r : 10'd0;
      oACTIVE   <= hAct_s && vAct_s;
      oFS       <= fs_s;
      actD_r[0] <= hAct_s && vAct_s;
      hsD_r[0]  <= hsN_s;
      vsD_r[0]  <= vsN_s;
      for (int i = 1; i < PIPE; i++) begin
        actD_r[i] <= actD_r[i-1];
        hsD_r[i]  <= hsD_r[i-1];
        vsD_r[i]  <= vsD_r[i-1];
      end
    end
  end

  // Output stage: colour sample gated by the aligned active flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R       <= 10'd0;
      oVGA_G       <= 10'd0;
      oVGA_B       <= 10'd0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      oVGA_R       <= actD_r[PIPE-1] ? iR : 10'd0;
      oVGA_G       <= actD_r[PIPE-1] ? iG : 10'd0;
      oVGA_B       <= actD_r[PIPE-1] ? iB : 10'd0;
      oVGA_HS      <= hsD_r[PIPE-1];
      oVGA_VS      <= vsD_r[PIPE-1];
      oVGA_BLANK_N <= actD_r[PIPE-1];
    end
  end

  assign oVGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench: three scan controllers (default timing, small timing with PIPE 3
// and PIPE 1) compared every cycle against an arithmetic raster model.
module tb_vga_scan_ctrl;

  typedef struct packed {
    int hact; int hfp; int hsync; int hbp;
    int vact; int vfp; int vsync; int vbp;
  } tim_t;

  typedef struct packed {
    logic [9:0] x; logic [9:0] y; logic act; logic fs; logic hs; logic vs;
  } geo_t;

  localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t TS = '{16, 3, 5, 4, 6, 2, 2, 3};
  localparam geo_t RST_G = '{10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstAC, rstB;
  logic [9:0] xA, yA, rA, gA, bA, iRA, iGA, iBA;
  logic [9:0] xB, yB, rB, gB, bB, iRB, iGB, iBB;
  logic [9:0] xC, yC, rC, gC, bC, iRC, iGC, iBC;
  logic actA, fsA, hsA, vsA, blA, syA;
  logic actB, fsB, hsB, vsB, blB, syB;
  logic actC, fsC, hsC, vsC, blC, syC;

  int total = 0;
  int bad = 0;
  int eA = 0, eB = 0, eC = 0;
  int modeB = 0;
  logic prevHsA = 1'b1;
  int aFall[$];
  int aRise[$];
  int cFs[$];
  int bFirstFs = -1;
  logic bArmed = 1'b0;
  logic [9:0] hxB [0:2];
  logic [9:0] hyB [0:2];

  vga_scan_ctrl dutA (
    .iCLK(clk), .iRST_N(rstAC), .oX(xA), .oY(yA), .oACTIVE(actA), .oFS(fsA),
    .iR(iRA), .iG(iGA), .iB(iBA), .oVGA_R(rA), .oVGA_G(gA), .oVGA_B(bA),
    .oVGA_HS(hsA), .oVGA_VS(vsA), .oVGA_BLANK_N(blA), .oVGA_SYNC_N(syA));

  vga_scan_ctrl #(.H_ACT(16), .H_FP(3), .H_SYNC(5), .H_BP(4), .V_ACT(6), .V_FP(2),
                  .V_SYNC(2), .V_BP(3), .PIPE(3)) dutB (
    .iCLK(clk), .iRST_N(rstB), .oX(xB), .oY(yB), .oACTIVE(actB), .oFS(fsB),
    .iR(iRB), .iG(iGB), .iB(iBB), .oVGA_R(rB), .oVGA_G(gB), .oVGA_B(bB),
    .oVGA_HS(hsB), .oVGA_VS(vsB), .oVGA_BLANK_N(blB), .oVGA_SYNC_N(syB));

  vga_scan_ctrl #(.H_ACT(16), .H_FP(3), .H_SYNC(5), .H_BP(4), .V_ACT(6), .V_FP(2),
                  .V_SYNC(2), .V_BP(3), .PIPE(1)) dutC (
    .iCLK(clk), .iRST_N(rstAC), .oX(xC), .oY(yC), .oACTIVE(actC), .oFS(fsC),
    .iR(iRC), .iG(iGC), .iB(iBC), .oVGA_R(rC), .oVGA_G(gC), .oVGA_B(bC),
    .oVGA_HS(hsC), .oVGA_VS(vsC), .oVGA_BLANK_N(blC), .oVGA_SYNC_N(syC));

  // Raster position n clocks after the counters left (0,0), derived from region widths.
  function automatic geo_t geom(input tim_t t, input int n);
    int htot, vtot, h, v;
    geo_t g;
    htot = t.hact + t.hfp + t.hsync + t.hbp;
    vtot = t.vact + t.vfp + t.vsync + t.vbp;
    h = n % htot;
    v = (n / htot) % vtot;
    g.act = (h < t.hact) && (v < t.vact);
    g.x   = (h < t.hact) ? 10'(h) : 10'd0;
    g.y   = (v < t.vact) ? 10'(v) : 10'd0;
    g.fs  = (h == 0) && (v == t.vact);
    g.hs  = !((h >= t.hact + t.hfp) && (h < t.hact + t.hfp + t.hsync));
    g.vs  = !((v >= t.vact + t.vfp) && (v < t.vact + t.vfp + t.vsync));
    return g;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // e = active edges since reset release; mode 1 expects the colour to echo the raster.
  task automatic checkDut(input string nm, input tim_t t, input int pipe, input int e,
                          input int mode, input logic [9:0] x, input logic [9:0] y,
                          input logic act, input logic fs, input logic [9:0] r,
                          input logic [9:0] g, input logic [9:0] b, input logic hs,
                          input logic vs, input logic bl, input logic sy,
                          input logic [9:0] inR, input logic [9:0] inG, input logic [9:0] inB);
    geo_t c, p;
    logic [9:0] er, eg, eb;
    c = (e == 0) ? RST_G : geom(t, e - 1);
    p = (e <= pipe) ? RST_G : geom(t, e - 1 - pipe);
    er = 10'd0; eg = 10'd0; eb = 10'd0;
    if (p.act) begin
      er = (mode == 1) ? p.x : inR;
      eg = (mode == 1) ? p.y : inG;
      eb = inB;
    end
    chk({nm, ".oX"}, 32'(x), 32'(c.x));
    chk({nm, ".oY"}, 32'(y), 32'(c.y));
    chk({nm, ".oACTIVE"}, 32'(act), 32'(c.act));
    chk({nm, ".oFS"}, 32'(fs), 32'(c.fs));
    chk({nm, ".HS"}, 32'(hs), 32'(p.hs));
    chk({nm, ".VS"}, 32'(vs), 32'(p.vs));
    chk({nm, ".BLANK_N"}, 32'(bl), 32'(p.act));
    chk({nm, ".SYNC_N"}, 32'(sy), 32'd0);
    chk({nm, ".R"}, 32'(r), 32'(er));
    chk({nm, ".G"}, 32'(g), 32'(eg));
    chk({nm, ".B"}, 32'(b), 32'(eb));
  endtask

  task automatic step();
    @(negedge clk);
    eA = rstAC ? eA + 1 : 0;
    eC = rstAC ? eC + 1 : 0;
    eB = rstB ? eB + 1 : 0;
    checkDut("A", TA, 1, eA, 0, xA, yA, actA, fsA, rA, gA, bA, hsA, vsA, blA, syA, iRA, iGA, iBA);
    checkDut("B", TS, 3, eB, modeB, xB, yB, actB, fsB, rB, gB, bB, hsB, vsB, blB, syB, iRB, iGB, iBB);
    checkDut("C", TS, 1, eC, 1, xC, yC, actC, fsC, rC, gC, bC, hsC, vsC, blC, syC, iRC, iGC, iBC);
    if (rstAC && prevHsA && !hsA) aFall.push_back(eA);
    if (rstAC && !prevHsA && hsA) aRise.push_back(eA);
    prevHsA = hsA;
    if (rstAC && fsC) cFs.push_back(eC);
    if (bArmed && fsB && bFirstFs < 0) bFirstFs = eB;
    // Visual-module models: C echoes coordinates directly, B through a two-deep history.
    iRC = xC;
    iGC = yC;
    iBC = 10'($urandom);
    hxB[2] = hxB[1]; hxB[1] = hxB[0]; hxB[0] = xB;
    hyB[2] = hyB[1]; hyB[1] = hyB[0]; hyB[0] = yB;
    iRB = (modeB == 1) ? hxB[2] : 10'($urandom);
    iGB = (modeB == 1) ? hyB[2] : 10'($urandom);
    iBB = 10'($urandom);
  endtask

  initial begin
    rstAC = 1'b0;
    rstB  = 1'b0;
    iRA = 10'd1023; iGA = 10'd1023; iBA = 10'd1023;
    iRB = 10'd0; iGB = 10'd0; iBB = 10'd0;
    iRC = 10'd0; iGC = 10'd0; iBC = 10'd0;
    for (int i = 0; i < 3; i++) begin
      hxB[i] = 10'd0;
      hyB[i] = 10'd0;
    end

    repeat (4) step();

    rstAC = 1'b1;
    rstB  = 1'b1;
    // Run B with random colour until it reaches line 4, pixel 10.
    repeat (4 * 28 + 10 + 1) step();

    rstB = 1'b0;
    #1;
    checkDut("Bmid", TS, 3, 0, 0, xB, yB, actB, fsB, rB, gB, bB, hsB, vsB, blB, syB, iRB, iGB, iBB);
    repeat (5) step();

    rstB  = 1'b1;
    modeB = 1;
    bArmed = 1'b1;
    repeat (1900) step();

    chk("A.hsFirstLow", 32'(qget(aFall, 0)), 32'd658);
    chk("A.hsWidth", 32'(qget(aRise, 0) - qget(aFall, 0)), 32'd96);
    chk("A.hsPeriod", 32'(qget(aFall, 1) - qget(aFall, 0)), 32'd800);
    chk("C.fsFirst", 32'(qget(cFs, 0)), 32'(6 * 28 + 1));
    chk("C.fsCount", 32'(cFs.size()), 32'((eC - 169) / 364 + 1));
    for (int i = 1; i < cFs.size(); i++) begin
      chk("C.fsGap", 32'(cFs[i] - cFs[i-1]), 32'd364);
    end
    chk("B.fsAfterReset", 32'(bFirstFs), 32'(6 * 28 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
